alu_exec_unit: RTL and testbench
================================

Name: alu_exec_unit

Overview:
Handshaked, multi-cycle integer execute unit that consumes the 3-bit ALUControl code produced by the ALU decoder and returns a result plus condition flags. Add, subtract and logic ops finish in one cycle. Shifts are iterative, one bit per cycle, to save area in the cached core. The unit sits between the decode/issue stage and writeback/branch logic; the zero flag drives branch resolution.

Parameters:
- WIDTH, 32, operand/result width in bits.
- SHAMT_W, $clog2(WIDTH), shift-amount width. Derived local parameter, not overridable.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operation request.
- in_ready  out  1  unit can accept a request (IDLE only).
- alu_ctrl  in  3  ALUControl code: 000 ADD, 010 SUB, 001 SLL, 100 XOR, 101 SRL, 110 OR, 111 AND, 011 reserved.
- src_a  in  WIDTH  operand A.
- src_b  in  WIDTH  operand B. Shifts use src_b[SHAMT_W-1:0] only.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  operation result.
- zero  out  1  result == 0.
- negative  out  1  result[WIDTH-1].
- carry  out  1  ADD: carry-out; SUB: no-borrow (A >= B unsigned); otherwise 0.
- overflow  out  1  signed overflow for ADD/SUB; otherwise 0.
- illegal  out  1  alu_ctrl was 011.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, out_valid=0, result=0, all flags 0, busy=0, internal shift counter=0. The reset takes effect immediately, including mid-SHIFT; any in-flight op is discarded.
- State machine:
  - IDLE: in_ready=1.
  - SHIFT: in_ready=0.
  - DONE: in_ready=0, out_valid=1.
- IDLE, accept when in_valid & in_ready at edge T. The unit latches alu_ctrl and operands.
  - Non-shift op, or shift with shamt=0: result and flags registered at T; move to DONE. out_valid is high from cycle T+1.
  - Shift with shamt=N>0: move to SHIFT with count=N. Each cycle shifts the working register by 1 (SLL fills with 0; SRL is logical, fills with 0) and decrements count. On the shift that makes count 0, load result and flags and go to DONE. out_valid is high from cycle T+1+N.
- DONE:
  - result and flags stay stable while out_ready=0.
  - On out_valid & out_ready, go to IDLE; out_valid drops the next cycle.
  - Max throughput is one op per 2 cycles; no accept in the pop cycle.
- Reserved code 011: result=0, zero=1, illegal=1, 1-cycle latency. Not an error stall.
- Arithmetic:
  - Computed modulo 2^WIDTH.
  - ADD overflow = (A[msb]==B[msb]) & (R[msb]!=A[msb]).
  - SUB is A + ~B + 1; carry is the carry-out of that sum.
  - SUB overflow = (A[msb]!=B[msb]) & (R[msb]!=A[msb]).
- in_valid, alu_ctrl and operand changes while not IDLE are ignored; there is no queuing.
- Flags for shifts and logic ops: zero and negative from the result; carry=0, overflow=0, illegal=0.

Decomposition:
- Shared package alu_pkg holds:
  - localparams for the seven ALUControl encodings plus ALU_RSVD=3'b011, shared with the ALU decoder.
  - the FSM state encoding (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2).
- One natural sub-module: alu_addsub. It is a combinational WIDTH-bit adder/subtractor producing sum, carry and overflow; it is instantiated once in alu_exec_unit.

Test Plan:
1. ADD A=0x7FFFFFFF, B=0x00000001, accepted at T → out_valid at T+1; result=0x80000000, negative=1, overflow=1, carry=0, zero=0.
2. SUB A=5, B=5 → result=0, zero=1, carry=1, overflow=0. Then SUB A=0, B=1 → result=0xFFFFFFFF, carry=0, negative=1.
3. SLL A=1, B=0x0000003F (shamt=31) accepted at T → busy=1 and in_ready=0 for T+1..T+32; out_valid at T+32; result=0x80000000. A second in_valid during SHIFT is ignored.
4. SRL A=0xF0000000, B=0 → result=0xF0000000 at T+1. SRL B=4 → result=0x0F000000 at T+5.
5. Backpressure: ADD result pending with out_ready=0 for 3 cycles → result and flags unchanged. Raise out_ready → IDLE next cycle and in_ready=1. Also alu_ctrl=011 → result=0, zero=1, illegal=1.
6. Assert rst_n=0 two cycles into an SLL with shamt=10 → out_valid, result and busy clear without waiting for clk. After release, OR A=0x0F0F0000, B=0x00000F0F → result=0x0F0F0F0F at T+1.

Source files
------------

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the integer execute unit and the ALU decoder:
//   - ALUControl encodings (ALU_ADD .. ALU_AND, ALU_RSVD)
//   - execute-unit FSM state encoding
//   - condition-flag bundle type
//   - is_shift() helper used to route ops to the iterative shifter
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SLL  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;
    localparam logic [2:0] ALU_RSVD = 3'b011;
    localparam logic [2:0] ALU_XOR  = 3'b100;
    localparam logic [2:0] ALU_SRL  = 3'b101;
    localparam logic [2:0] ALU_OR   = 3'b110;
    localparam logic [2:0] ALU_AND  = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } alu_state_t;

    typedef struct packed {
        logic zero;
        logic negative;
        logic carry;
        logic overflow;
        logic illegal;
    } alu_flags_t;

    // True for the two codes handled by the one-bit-per-cycle shifter.
    function automatic logic is_shift(input logic [2:0] ctrl);
        return (ctrl == ALU_SLL) || (ctrl == ALU_SRL);
    endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// -----------------------------------------------------------------------------
// alu_exec_unit_if
// Request/response bundle between issue, the execute unit and writeback.
//   request : in_valid, in_ready, alu_ctrl, src_a, src_b
//   response: out_valid, out_ready, result, zero, negative, carry, overflow,
//             illegal
//   status  : busy
// master = issue/writeback side, slave = execute unit.
// -----------------------------------------------------------------------------
interface alu_exec_unit_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       alu_ctrl;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             negative;
    logic             carry;
    logic             overflow;
    logic             illegal;
    logic             busy;

    modport master (
        output in_valid, alu_ctrl, src_a, src_b, out_ready,
        input  in_ready, out_valid, result, zero, negative, carry, overflow,
               illegal, busy
    );

    modport slave (
        input  in_valid, alu_ctrl, src_a, src_b, out_ready,
        output in_ready, out_valid, result, zero, negative, carry, overflow,
               illegal, busy
    );
endinterface

// File: rtl/alu_addsub.sv
// -----------------------------------------------------------------------------
// alu_addsub
// Combinational WIDTH-bit adder/subtractor. Subtraction is a + ~b + 1, so
// carry doubles as "no borrow" (a >= b unsigned).
//   a, b     : operands
//   sub      : 1 = subtract, 0 = add
//   sum      : result modulo 2^WIDTH
//   carry    : carry-out of the sum
//   overflow : signed overflow
// -----------------------------------------------------------------------------
module alu_addsub #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);
    logic [WIDTH-1:0] b_eff_s;
    logic [WIDTH:0]   total_s;

    // Single adder; subtract by inverting b and injecting sub as carry-in.
    always_comb begin
        b_eff_s  = sub ? ~b : b;
        total_s  = {1'b0, a} + {1'b0, b_eff_s} + {{WIDTH{1'b0}}, sub};
        sum      = total_s[WIDTH-1:0];
        carry    = total_s[WIDTH];
        if (sub) begin
            overflow = (a[WIDTH-1] != b[WIDTH-1]) & (sum[WIDTH-1] != a[WIDTH-1]);
        end else begin
            overflow = (a[WIDTH-1] == b[WIDTH-1]) & (sum[WIDTH-1] != a[WIDTH-1]);
        end
    end
endmodule

// File: rtl/alu_exec_unit.sv
// -----------------------------------------------------------------------------
// alu_exec_unit
// Handshaked multi-cycle integer execute unit. ADD/SUB/logic ops and
// zero-amount shifts complete in one cycle; shifts by N>0 take N cycles in a
// one-bit-per-cycle shifter. The result is held in DONE until popped.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : alu_exec_unit_if.slave (request, response, flags, busy)
// -----------------------------------------------------------------------------
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_exec_unit_if.slave       bus
);
    localparam int SHAMT_W = $clog2(WIDTH);

    alu_state_t         state_r,  state_s;
    logic [SHAMT_W-1:0] cnt_r,    cnt_s;
    logic [WIDTH-1:0]   work_r,   work_s;
    logic [2:0]         op_r,     op_s;
    logic [WIDTH-1:0]   result_r, result_s;
    alu_flags_t         flags_r,  flags_s;

    logic [SHAMT_W-1:0] shamt_s;
    logic [WIDTH-1:0]   shifted_s;
    logic [WIDTH-1:0]   as_sum_s;
    logic               as_carry_s;
    logic               as_ovf_s;
    logic               as_sub_s;

    function automatic alu_flags_t mk_flags(input logic [WIDTH-1:0] r,
                                            input logic c,
                                            input logic v,
                                            input logic ill);
        alu_flags_t f;
        f.zero     = (r == {WIDTH{1'b0}});
        f.negative = r[WIDTH-1];
        f.carry    = c;
        f.overflow = v;
        f.illegal  = ill;
        return f;
    endfunction

    assign shamt_s  = bus.src_b[SHAMT_W-1:0];
    assign as_sub_s = (bus.alu_ctrl == ALU_SUB);
    // One step of the iterative shifter; both directions fill with zero.
    assign shifted_s = (op_r == ALU_SLL) ? {work_r[WIDTH-2:0], 1'b0}
                                         : {1'b0, work_r[WIDTH-1:1]};

    alu_addsub #(.WIDTH(WIDTH)) u_addsub (
        .a        (bus.src_a),
        .b        (bus.src_b),
        .sub      (as_sub_s),
        .sum      (as_sum_s),
        .carry    (as_carry_s),
        .overflow (as_ovf_s)
    );

    // Next-state, datapath and flag computation.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        work_s   = work_r;
        op_s     = op_r;
        result_s = result_r;
        flags_s  = flags_r;
        case (state_r)
            IDLE: begin
                if (bus.in_valid) begin
                    state_s = DONE;
                    case (bus.alu_ctrl)
                        ALU_ADD, ALU_SUB: begin
                            result_s = as_sum_s;
                            flags_s  = mk_flags(as_sum_s, as_carry_s, as_ovf_s, 1'b0);
                        end
                        ALU_XOR: begin
                            result_s = bus.src_a ^ bus.src_b;
                            flags_s  = mk_flags(bus.src_a ^ bus.src_b, 1'b0, 1'b0, 1'b0);
                        end
                        ALU_OR: begin
                            result_s = bus.src_a | bus.src_b;
                            flags_s  = mk_flags(bus.src_a | bus.src_b, 1'b0, 1'b0, 1'b0);
                        end
                        ALU_AND: begin
                            result_s = bus.src_a & bus.src_b;
                            flags_s  = mk_flags(bus.src_a & bus.src_b, 1'b0, 1'b0, 1'b0);
                        end
                        ALU_SLL, ALU_SRL: begin
                            if (shamt_s == SHAMT_W'(0)) begin
                                result_s = bus.src_a;
                                flags_s  = mk_flags(bus.src_a, 1'b0, 1'b0, 1'b0);
                            end else begin
                                state_s = SHIFT;
                                work_s  = bus.src_a;
                                cnt_s   = shamt_s;
                                op_s    = bus.alu_ctrl;
                            end
                        end
                        default: begin
                            // ALU_RSVD: report as illegal with a zero result.
                            result_s = {WIDTH{1'b0}};
                            flags_s  = mk_flags({WIDTH{1'b0}}, 1'b0, 1'b0, 1'b1);
                        end
                    endcase
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                work_s = shifted_s;
                cnt_s  = cnt_r - SHAMT_W'(1);
                if (cnt_r == SHAMT_W'(1)) begin
                    state_s  = DONE;
                    result_s = shifted_s;
                    flags_s  = mk_flags(shifted_s, 1'b0, 1'b0, 1'b0);
                end else begin
                    state_s = SHIFT;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            cnt_r    <= SHAMT_W'(0);
            work_r   <= {WIDTH{1'b0}};
            op_r     <= 3'b000;
            result_r <= {WIDTH{1'b0}};
            flags_r  <= '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            work_r   <= work_s;
            op_r     <= op_s;
            result_r <= result_s;
            flags_r  <= flags_s;
        end
    end

    assign bus.in_ready  = (state_r == IDLE);
    assign bus.out_valid = (state_r == DONE);
    assign bus.busy      = (state_r != IDLE);
    assign bus.result    = result_r;
    assign bus.zero      = flags_r.zero;
    assign bus.negative  = flags_r.negative;
    assign bus.carry     = flags_r.carry;
    assign bus.overflow  = flags_r.overflow;
    assign bus.illegal   = flags_r.illegal;
endmodule

// File: tb/tb_alu_exec_unit.sv
// -----------------------------------------------------------------------------
// tb_alu_exec_unit
// Directed self-checking bench for alu_exec_unit. Flags are compared as the
// 5-bit vector {zero, negative, carry, overflow, illegal}.
// -----------------------------------------------------------------------------
module tb_alu_exec_unit;
    import alu_pkg::*;

    logic clk;
    logic rst_n;
    int   errors_n;
    int   checks_n;

    alu_exec_unit_if #(.WIDTH(32)) bus ();

    alu_exec_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_n++;
        if (got !== exp) begin
            errors_n++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] flags_vec();
        return {27'd0, bus.zero, bus.negative, bus.carry, bus.overflow, bus.illegal};
    endfunction

    // Present one request at the negedge; returns just after the accept edge.
    task automatic issue(input logic [2:0] ctrl, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.alu_ctrl = ctrl;
        bus.src_a    = a;
        bus.src_b    = b;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Pop the pending result and confirm the unit is back in IDLE next cycle.
    task automatic pop(input string tag);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        check_eq({tag, ".pop_valid"}, {31'd0, bus.out_valid}, 32'd0);
        check_eq({tag, ".pop_ready"}, {31'd0, bus.in_ready}, 32'd1);
    endtask

    // Issue an op, check out_valid appears exactly lat cycles after accept.
    task automatic run_op(input string tag, input logic [2:0] ctrl,
                          input logic [31:0] a, input logic [31:0] b, input int lat,
                          input logic [31:0] exp_res, input logic [4:0] exp_flags);
        issue(ctrl, a, b);
        for (int k = 1; k < lat; k++) begin
            @(negedge clk);
            check_eq({tag, ".early_valid"}, {31'd0, bus.out_valid}, 32'd0);
        end
        @(negedge clk);
        check_eq({tag, ".valid"}, {31'd0, bus.out_valid}, 32'd1);
        check_eq({tag, ".result"}, bus.result, exp_res);
        check_eq({tag, ".flags"}, flags_vec(), {27'd0, exp_flags});
        pop(tag);
    endtask

    initial begin
        errors_n      = 0;
        checks_n      = 0;
        rst_n         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.alu_ctrl  = 3'b000;
        bus.src_a     = 32'd0;
        bus.src_b     = 32'd0;
        bus.out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst.out_valid", {31'd0, bus.out_valid}, 32'd0);
        check_eq("rst.in_ready", {31'd0, bus.in_ready}, 32'd1);
        check_eq("rst.busy", {31'd0, bus.busy}, 32'd0);
        check_eq("rst.result", bus.result, 32'd0);
        check_eq("rst.flags", flags_vec(), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // flags order: zero negative carry overflow illegal
        run_op("add_ovf", ALU_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 1, 32'h8000_0000, 5'b01010);
        run_op("sub_eq", ALU_SUB, 32'h0000_0005, 32'h0000_0005, 1, 32'h0000_0000, 5'b10100);
        run_op("sub_borrow", ALU_SUB, 32'h0000_0000, 32'h0000_0001, 1, 32'hFFFF_FFFF, 5'b01000);
        run_op("xor", ALU_XOR, 32'hFF00_FF00, 32'h0F0F_0F0F, 1, 32'hF00F_F00F, 5'b01000);
        run_op("and", ALU_AND, 32'hFF00_FF00, 32'h0F0F_0F0F, 1, 32'h0F00_0F00, 5'b00000);
        run_op("srl0", ALU_SRL, 32'hF000_0000, 32'h0000_0000, 1, 32'hF000_0000, 5'b01000);
        run_op("srl4", ALU_SRL, 32'hF000_0000, 32'h0000_0004, 5, 32'h0F00_0000, 5'b00000);
        run_op("rsvd", ALU_RSVD, 32'h1234_5678, 32'h9ABC_DEF0, 1, 32'h0000_0000, 5'b10001);

        // SLL by 31 (upper src_b bits ignored); a request during SHIFT is ignored.
        issue(ALU_SLL, 32'h0000_0001, 32'h0000_003F);
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            if (k == 2) begin
                bus.in_valid = 1'b1;
                bus.alu_ctrl = ALU_ADD;
                bus.src_a    = 32'h0000_0001;
                bus.src_b    = 32'h0000_0001;
            end else if (k == 5) begin
                bus.in_valid = 1'b0;
            end
            check_eq("sll31.busy", {31'd0, bus.busy}, 32'd1);
            check_eq("sll31.in_ready", {31'd0, bus.in_ready}, 32'd0);
            check_eq("sll31.valid", {31'd0, bus.out_valid}, (k == 32) ? 32'd1 : 32'd0);
        end
        check_eq("sll31.result", bus.result, 32'h8000_0000);
        check_eq("sll31.flags", flags_vec(), {27'd0, 5'b01000});
        pop("sll31");

        // Backpressure: ADD wrapping to zero held for three cycles.
        issue(ALU_ADD, 32'hFFFF_FFFF, 32'h0000_0001);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check_eq("bp.valid", {31'd0, bus.out_valid}, 32'd1);
            check_eq("bp.result", bus.result, 32'h0000_0000);
            check_eq("bp.flags", flags_vec(), {27'd0, 5'b10100});
        end
        pop("bp");

        // Put a nonzero result on the outputs so the reset clear is visible.
        run_op("xor2", ALU_XOR, 32'h0000_00FF, 32'h0000_0F00, 1, 32'h0000_0FFF, 5'b00000);

        // Asynchronous reset two cycles into SLL by 10.
        issue(ALU_SLL, 32'h0000_0001, 32'h0000_000A);
        repeat (2) @(negedge clk);
        check_eq("arst.pre_busy", {31'd0, bus.busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst.out_valid", {31'd0, bus.out_valid}, 32'd0);
        check_eq("arst.busy", {31'd0, bus.busy}, 32'd0);
        check_eq("arst.result", bus.result, 32'd0);
        check_eq("arst.flags", flags_vec(), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("or", ALU_OR, 32'h0F0F_0000, 32'h0000_0F0F, 1, 32'h0F0F_0F0F, 5'b00000);

        $display("Result: errors=%0d of %0d checks", errors_n, checks_n);
        $finish;
    end
endmodule
